// File: rtl/frame_tx_sequencer.sv
// frame_tx_sequencer: walks the byte multiplexer through one game-state frame
// (start byte, 3 data bytes, 64 map bytes, end byte) and paces the UART with a
// start/done handshake. All outputs are registered and decoded from the state
// being entered, so each one lines up exactly with its state.
module frame_tx_sequencer #(
  parameter int NUM_BYTES      = 69,
  parameter int SEL_WIDTH      = 7,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic                 abort,
  input  logic                 tx_done,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 tx_start,
  output logic                 snapshot,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err
);

  localparam int TCNT_WIDTH   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GCNT_WIDTH   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LAST_INT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [SEL_WIDTH-1:0]  SEL_ZERO  = {SEL_WIDTH{1'b0}};
  localparam logic [SEL_WIDTH-1:0]  SEL_ONE   = SEL_WIDTH'(32'd1);
  localparam logic [SEL_WIDTH-1:0]  SEL_LAST  = SEL_WIDTH'(NUM_BYTES - 1);
  localparam logic [TCNT_WIDTH-1:0] TCNT_ZERO = {TCNT_WIDTH{1'b0}};
  localparam logic [TCNT_WIDTH-1:0] TCNT_ONE  = TCNT_WIDTH'(32'd1);
  localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TO_LAST_INT);
  localparam logic [GCNT_WIDTH-1:0] GCNT_ZERO = {GCNT_WIDTH{1'b0}};
  localparam logic [GCNT_WIDTH-1:0] GCNT_ONE  = GCNT_WIDTH'(32'd1);
  localparam logic [GCNT_WIDTH-1:0] GCNT_LAST = GCNT_WIDTH'(GAP_LAST_INT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [SEL_WIDTH-1:0]  sel_r, sel_s;
  logic                  pending_r, pending_s;
  logic [TCNT_WIDTH-1:0] tcnt_r, tcnt_s;
  logic [GCNT_WIDTH-1:0] gcnt_r, gcnt_s;
  logic                  terr_s;

  logic tx_start_r, snapshot_r, busy_r, frame_done_r, timeout_err_r;
  logic tx_start_s, snapshot_s, busy_s, frame_done_s, timeout_err_s;

  // State, byte index, pending request and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      sel_r     <= SEL_ZERO;
      pending_r <= 1'b0;
      tcnt_r    <= TCNT_ZERO;
      gcnt_r    <= GCNT_ZERO;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      pending_r <= pending_s;
      tcnt_r    <= tcnt_s;
      gcnt_r    <= gcnt_s;
    end
  end

  // Next-state logic; abort overrides everything, a request seen while a frame
  // is running (including the DONE cycle) is remembered one deep.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    pending_s = pending_r | (send & (state_r != ST_IDLE));
    tcnt_s    = tcnt_r;
    gcnt_s    = gcnt_r;
    terr_s    = 1'b0;
    if (abort) begin
      state_s   = ST_IDLE;
      sel_s     = SEL_ZERO;
      pending_s = 1'b0;
      tcnt_s    = TCNT_ZERO;
      gcnt_s    = GCNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sel_s = SEL_ZERO;
          if (send) begin
            state_s = ST_LATCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LATCH: begin
          state_s = ST_START;
        end
        ST_START: begin
          state_s = ST_WAIT;
          tcnt_s  = TCNT_ZERO;
        end
        ST_WAIT: begin
          // tx_done is checked first so a completion on the expiry cycle wins
          if (tx_done) begin
            if (sel_r == SEL_LAST) begin
              state_s = ST_DONE;
            end else begin
              sel_s  = sel_r + SEL_ONE;
              gcnt_s = GCNT_ZERO;
              if (GAP_CYCLES == 0) begin
                state_s = ST_START;
              end else begin
                state_s = ST_GAP;
              end
            end
          end else if (tcnt_r == TCNT_LAST) begin
            state_s   = ST_IDLE;
            sel_s     = SEL_ZERO;
            pending_s = 1'b0;
            terr_s    = 1'b1;
          end else begin
            tcnt_s = tcnt_r + TCNT_ONE;
          end
        end
        ST_GAP: begin
          if (gcnt_r == GCNT_LAST) begin
            state_s = ST_START;
          end else begin
            gcnt_s = gcnt_r + GCNT_ONE;
          end
        end
        ST_DONE: begin
          sel_s = SEL_ZERO;
          if (pending_s) begin
            state_s   = ST_LATCH;
            pending_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          sel_s     = SEL_ZERO;
          pending_s = 1'b0;
          tcnt_s    = TCNT_ZERO;
          gcnt_s    = GCNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the state being entered, so registered outputs track state.
  always_comb begin
    tx_start_s    = (state_s == ST_START);
    snapshot_s    = (state_s == ST_LATCH);
    busy_s        = (state_s != ST_IDLE);
    frame_done_s  = (state_s == ST_DONE);
    timeout_err_s = terr_s;
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_start_r    <= 1'b0;
      snapshot_r    <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      tx_start_r    <= tx_start_s;
      snapshot_r    <= snapshot_s;
      busy_r        <= busy_s;
      frame_done_r  <= frame_done_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign sel         = sel_r;
  assign tx_start    = tx_start_r;
  assign snapshot    = snapshot_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Testbench for frame_tx_sequencer: a UART model answers each tx_start after a
// fixed or random latency, a monitor tallies the observable events, and the
// expected figures come from the frame-length rule and the byte ordering rule.
module tb_frame_tx_sequencer;

  localparam int NB  = 69;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic       clock;
  logic       reset_n;
  logic       send;
  logic       abort;
  logic       uart_done;
  logic       force_done;
  logic       tx_done_s;
  logic [6:0] sel;
  logic       tx_start, snapshot, busy, frame_done, timeout_err;

  assign tx_done_s = uart_done | force_done;

  frame_tx_sequencer #(
    .NUM_BYTES(NB), .SEL_WIDTH(7), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .send(send), .abort(abort),
    .tx_done(tx_done_s), .sel(sel), .tx_start(tx_start), .snapshot(snapshot),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // bench controls
  logic mon_clr;
  int   uart_k;
  logic uart_rand;
  int   withhold_sel;

  // UART model state
  int u_cnt;
  int u_k;
  int uart_sum;

  // monitor tallies
  int cyc, busy_cyc, snap_cnt, start_cnt, fd_cnt, to_cnt, b2b_cnt;
  int order_err, range_err, exp_idx, start5_t, to_t;
  logic fd_prev;

  // UART model: raise tx_done k cycles after each tx_start, unless withheld
  always @(negedge clock) begin
    if (mon_clr || !reset_n) begin
      u_cnt = 0; uart_done = 1'b0; uart_sum = 0;
    end else begin
      uart_done = 1'b0;
      if (tx_start) begin
        if (int'(sel) == withhold_sel) begin
          u_cnt = 0;
        end else begin
          u_k = uart_rand ? int'($urandom_range(16, 1)) : uart_k;
          u_cnt = u_k;
          uart_sum = uart_sum + 1 + u_k;
        end
      end else if (u_cnt > 0) begin
        u_cnt = u_cnt - 1;
        if (u_cnt == 0) uart_done = 1'b1;
      end
    end
  end

  // Event monitor
  always @(negedge clock) begin
    if (mon_clr) begin
      cyc = 0; busy_cyc = 0; snap_cnt = 0; start_cnt = 0; fd_cnt = 0; to_cnt = 0;
      b2b_cnt = 0; order_err = 0; range_err = 0; exp_idx = 0; start5_t = -1;
      to_t = -1; fd_prev = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (busy) busy_cyc = busy_cyc + 1;
      if (snapshot) begin
        snap_cnt = snap_cnt + 1;
        exp_idx = 0;
        if (fd_prev) b2b_cnt = b2b_cnt + 1;
      end
      if (tx_start) begin
        start_cnt = start_cnt + 1;
        if (int'(sel) != exp_idx) order_err = order_err + 1;
        if (int'(sel) == 5) start5_t = cyc;
        exp_idx = exp_idx + 1;
      end
      if (int'(sel) > NB - 1) range_err = range_err + 1;
      if (frame_done) fd_cnt = fd_cnt + 1;
      if (timeout_err) begin
        to_cnt = to_cnt + 1;
        to_t = cyc;
      end
      fd_prev = frame_done;
    end
  end

  function automatic int frame_len(input int k);
    return 1 + NB * (1 + k) + (NB - 1) * GAP + 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_fd(input int n, input int limit, input string name);
    int i = 0;
    while (fd_cnt < n && i < limit) begin
      tick();
      i++;
    end
    check(name, (fd_cnt >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_sel(input int v, input int limit, input string name);
    int i = 0;
    while (int'(sel) != v && i < limit) begin
      tick();
      i++;
    end
    check(name, (int'(sel) == v) ? 1 : 0, 1);
  endtask

  typedef struct {
    int k;
    int rnd;
    int exp_busy;
    int exp_starts;
    int exp_fd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // frame scenarios: UART latency and the expected frame figures
    vecs[0] = '{k: 1,  rnd: 0, exp_busy: frame_len(1),  exp_starts: NB, exp_fd: 1};
    vecs[1] = '{k: 10, rnd: 0, exp_busy: frame_len(10), exp_starts: NB, exp_fd: 1};
    vecs[2] = '{k: 15, rnd: 0, exp_busy: frame_len(15), exp_starts: NB, exp_fd: 1};
    // k = TO lands tx_done exactly on the timeout-expiry cycle
    vecs[3] = '{k: TO, rnd: 0, exp_busy: frame_len(TO), exp_starts: NB, exp_fd: 1};
    vecs[4] = '{k: 0,  rnd: 1, exp_busy: -1,            exp_starts: NB, exp_fd: 1};

    reset_n = 1'b0; send = 1'b0; abort = 1'b0; force_done = 1'b0; mon_clr = 1'b0;
    uart_k = 10; uart_rand = 1'b0; withhold_sel = -1;
    tick(); tick(); tick();
    check("reset_sel", int'(sel), 0);
    check("reset_outs", int'({tx_start, snapshot, busy, frame_done, timeout_err}), 0);
    reset_n = 1'b1;
    tick();

    // table-driven full frames
    for (int v = 0; v < 5; v++) begin
      int exp_busy;
      uart_k = vecs[v].k;
      uart_rand = (vecs[v].rnd != 0);
      clear_mon();
      pulse_send();
      wait_fd(1, 5000, $sformatf("v%0d_reach_done", v));
      tick(); tick(); tick();
      exp_busy = (vecs[v].rnd != 0) ? (2 + uart_sum + (NB - 1) * GAP) : vecs[v].exp_busy;
      check($sformatf("v%0d_busy_len", v), busy_cyc, exp_busy);
      check($sformatf("v%0d_starts", v), start_cnt, vecs[v].exp_starts);
      check($sformatf("v%0d_order", v), order_err, 0);
      check($sformatf("v%0d_snap", v), snap_cnt, 1);
      check($sformatf("v%0d_fdone", v), fd_cnt, vecs[v].exp_fd);
      check($sformatf("v%0d_tout", v), to_cnt, 0);
      check($sformatf("v%0d_range", v), range_err, 0);
      check($sformatf("v%0d_idle", v), int'({busy, sel}), 0);
    end
    uart_rand = 1'b0;

    // back-to-back request while sel == 30
    uart_k = 10;
    clear_mon();
    pulse_send();
    wait_sel(30, 2000, "b2b_reach_sel30");
    pulse_send();
    wait_fd(2, 4000, "b2b_reach_done2");
    repeat (40) tick();
    check("b2b_fdone", fd_cnt, 2);
    check("b2b_snap", snap_cnt, 2);
    check("b2b_latch_after_done", b2b_cnt, 1);
    check("b2b_starts", start_cnt, 2 * NB);
    check("b2b_busy_len", busy_cyc, 2 * frame_len(10));
    check("b2b_order", order_err, 0);

    // timeout: UART never answers the byte at sel 5
    withhold_sel = 5;
    clear_mon();
    pulse_send();
    begin
      int i = 0;
      while (to_cnt < 1 && i < 2000) begin
        tick();
        i++;
      end
    end
    check("to_seen", to_cnt, 1);
    check("to_latency", to_t - start5_t, TO + 1);
    check("to_after_busy", int'(busy), 0);
    check("to_after_sel", int'(sel), 0);
    check("to_one_cycle", int'(timeout_err), 0);
    check("to_starts", start_cnt, 6);
    repeat (30) tick();
    check("to_no_fdone", fd_cnt, 0);
    check("to_no_restart", snap_cnt, 1);
    withhold_sel = -1;

    // abort at sel 40 with send also high
    clear_mon();
    pulse_send();
    wait_sel(40, 2000, "ab_reach_sel40");
    abort = 1'b1; send = 1'b1;
    tick();
    abort = 1'b0; send = 1'b0;
    check("ab_busy", int'(busy), 0);
    check("ab_sel", int'(sel), 0);
    repeat (60) tick();
    check("ab_no_fdone", fd_cnt, 0);
    check("ab_no_restart", snap_cnt, 1);
    check("ab_starts", start_cnt, 40);
    check("ab_no_tout", to_cnt, 0);

    // spurious tx_done in IDLE
    clear_mon();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    check("sp_idle_state", int'({busy, sel}), 0);
    check("sp_idle_nosnap", snap_cnt, 0);

    // spurious tx_done during GAP
    uart_k = 4;
    clear_mon();
    pulse_send();
    wait_sel(3, 500, "sp_gap_reach_sel3");
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("sp_gap_sel_held", int'(sel), 3);
    wait_fd(1, 5000, "sp_gap_reach_done");
    tick(); tick();
    check("sp_gap_starts", start_cnt, NB);
    check("sp_gap_order", order_err, 0);
    check("sp_gap_busy_len", busy_cyc, frame_len(4));

    // asynchronous reset in WAIT at sel 12
    uart_k = 10;
    clear_mon();
    pulse_send();
    wait_sel(12, 2000, "ar_reach_sel12");
    tick(); tick(); tick();
    check("ar_busy_before", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_sel_now", int'(sel), 0);
    check("ar_outs_now", int'({tx_start, snapshot, busy, frame_done, timeout_err}), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    clear_mon();
    pulse_send();
    wait_fd(1, 5000, "ar_reach_done");
    tick(); tick();
    check("ar_starts", start_cnt, NB);
    check("ar_order", order_err, 0);
    check("ar_snap", snap_cnt, 1);
    check("ar_busy_len", busy_cyc, frame_len(10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
